reg_dump_streamer: RTL and testbench

Initiator that walks the 8-entry register file through its two read ports and streams every register out, in address order, as an address/data pair with a valid/ready handshake. It drives RaddrA/RaddrB into the register file and consumes the file's combinational DataOutA/DataOutB. It sits beside the register file as its debug/snapshot reader, e.g. feeding a trace or UART path.

---
 rtl/reg_dump_streamer.sv | 157 +++++++++++++++
 tb/tb_reg_dump_streamer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : reg_dump_streamer
//  Purpose  : Walks a register file two entries at a time through its A/B
//             read ports and streams every register out in address order
//             as (address, data) beats over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump_streamer #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] RaddrA,
  output logic [ADDR_W-1:0] RaddrB,
  input  logic [DATA_W-1:0] DataOutA,
  input  logic [DATA_W-1:0] DataOutB,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ADDR_W-1:0] OutAddr,
  output logic [DATA_W-1:0] OutData
);

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(NUM_REGS / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_SEND_A = 3'd2,
    S_SEND_B = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pair_idx;
  logic [ADDR_W-1:0]   w_pair_idx_nxt;
  logic [DATA_W-1:0]   r_buf_a;
  logic [DATA_W-1:0]   r_buf_b;
  logic [ADDR_W-1:0]   w_addr_a;
  logic [ADDR_W-1:0]   w_addr_b;
  logic                w_handshake;

  // Pair addresses are derived from the pair index alone, so the read
  // ports already point at pair 0 (0/1) while idle or in reset.
  always_comb begin
    w_addr_a    = r_pair_idx << 1;
    w_addr_b    = w_addr_a | ADDR_W'(1);
    w_handshake = OutReady && (r_state == S_SEND_A || r_state == S_SEND_B);
  end

  // State and pair-index register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_pair_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pair_idx <= w_pair_idx_nxt;
    end
  end

  // Snapshot the pair during the single READ cycle; later writes to the
  // file are deliberately not seen by this pair.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_buf_a <= '0;
      r_buf_b <= '0;
    end else if (r_state == S_READ) begin
      r_buf_a <= DataOutA;
      r_buf_b <= DataOutB;
    end
  end

  // Next-state and pair-index sequencing; Start only matters in IDLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_pair_idx_nxt = r_pair_idx;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt    = S_READ;
          w_pair_idx_nxt = '0;
        end
      end
      S_READ: begin
        w_state_nxt = S_SEND_A;
      end
      S_SEND_A: begin
        if (w_handshake) begin
          w_state_nxt = S_SEND_B;
        end
      end
      S_SEND_B: begin
        if (w_handshake) begin
          if (r_pair_idx == C_LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt    = S_READ;
            w_pair_idx_nxt = r_pair_idx + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt    = S_IDLE;
        w_pair_idx_nxt = '0;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_pair_idx_nxt = '0;
      end
    endcase
  end

  // Output decode from state, pair index and capture buffers only, so no
  // input ever reaches an output combinationally.
  always_comb begin
    Busy     = 1'b0;
    Done     = 1'b0;
    OutValid = 1'b0;
    OutAddr  = '0;
    OutData  = '0;
    RaddrA   = w_addr_a;
    RaddrB   = w_addr_b;
    case (r_state)
      S_READ: begin
        Busy = 1'b1;
      end
      S_SEND_A: begin
        Busy     = 1'b1;
        OutValid = 1'b1;
        OutAddr  = w_addr_a;
        OutData  = r_buf_a;
      end
      S_SEND_B: begin
        Busy     = 1'b1;
        OutValid = 1'b1;
        OutAddr  = w_addr_b;
        OutData  = r_buf_b;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_reg_dump_streamer
//  Purpose  : Self-checking bench for reg_dump_streamer with a behavioural
//             register file and an expected-beat table.
//  Revision : 1.0  initial release
// ============================================================================

module tb_reg_dump_streamer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       OutReady = 1'b1;
    logic       Busy, Done, OutValid;
    logic [2:0] RaddrA, RaddrB, OutAddr;
    logic [7:0] DataOutA, DataOutB, OutData;

    logic [7:0] regs     [8];
    logic [7:0] exp_data [8];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    reg_dump_streamer #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
        .RaddrA   (RaddrA),
        .RaddrB   (RaddrB),
        .DataOutA (DataOutA),
        .DataOutB (DataOutB),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutAddr  (OutAddr),
        .OutData  (OutData)
    );

    assign DataOutA = regs[RaddrA];
    assign DataOutB = regs[RaddrB];

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        if (obs !== expv) begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_dump(input int mode);
        int         e, first_v, done_cnt, done_cyc, stalls, stall3, iter;
        logic       held, rdy;
        logic [2:0] h_addr;
        logic [7:0] h_data;
        logic [2:0] q_addr[$];
        logic [7:0] q_data[$];
        first_v  = -1;
        done_cnt = 0;
        done_cyc = -1;
        stalls   = 0;
        stall3   = 0;
        held     = 1'b0;
        h_addr   = '0;
        h_data   = '0;
        Start    = 1'b1;
        step();
        Start    = 1'b0;
        e        = cyc;
        iter     = 0;
        while (done_cnt == 0 && iter < 300) begin
            if (held) begin
                check("held addr", OutAddr, h_addr);
                check("held data", OutData, h_data);
            end
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
            end else begin
                if (OutValid && first_v < 0) first_v = cyc;
                rdy   = 1'b1;
                Start = 1'b0;
                case (mode)
                    1: if (OutValid && OutAddr == 3'd3 && stall3 < 3) rdy = 1'b0;
                    2: Start = (cyc == e + 5);
                    3: begin
                        if (OutValid && OutAddr == 3'd2) regs[5] = 8'd99;
                        if (OutValid && OutAddr == 3'd1) regs[0] = 8'd77;
                    end
                    4: rdy = ($urandom_range(0, 2) != 0);
                    default: rdy = 1'b1;
                endcase
                if (OutValid && !rdy) begin
                    stalls++;
                    if (OutAddr == 3'd3) stall3++;
                end
                if (OutValid && rdy) begin
                    q_addr.push_back(OutAddr);
                    q_data.push_back(OutData);
                end
                held     = OutValid && !rdy;
                h_addr   = OutAddr;
                h_data   = OutData;
                OutReady = rdy;
                step();
            end
            iter++;
        end
        check("done seen", done_cnt, 1);
        check("first valid latency", first_v - e, 1);
        check("done latency", done_cyc - e, 12 + stalls);
        if (mode == 1) check("stall count addr3", stall3, 3);
        check("beat count", q_addr.size(), 8);
        for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
            check("beat addr", q_addr[i], i[2:0]);
            check("beat data", q_data[i], exp_data[i]);
        end
        OutReady = 1'b1;
        Start    = (mode == 2);
        step();
        Start    = 1'b0;
        check("done single pulse", Done, 1'b0);
        check("busy after done", Busy, 1'b0);
        step();
        check("busy idle", Busy, 1'b0);
        check("valid idle", OutValid, 1'b0);
    endtask

    initial begin
        int iter;
        for (int i = 0; i < 8; i++) regs[i] = 8'd0;
        Reset = 1'b1;
        step();
        step();
        check("reset busy", Busy, 1'b0);
        check("reset done", Done, 1'b0);
        check("reset valid", OutValid, 1'b0);
        check("reset raddrA", RaddrA, 3'd0);
        check("reset raddrB", RaddrB, 3'd1);
        Reset = 1'b0;
        step();

        regs[2] = 8'd22; regs[3] = 8'd16; regs[1] = 8'd8; regs[7] = 8'd15;
        exp_data = regs;
        do_dump(0);
        do_dump(1);
        do_dump(2);

        exp_data    = regs;
        exp_data[5] = 8'd99;
        do_dump(3);
        regs[0] = 8'd0;
        regs[5] = 8'd0;

        Start = 1'b1;
        step();
        Start = 1'b0;
        iter  = 0;
        while (!(OutValid && OutAddr == 3'd4) && iter < 50) begin
            step();
            iter++;
        end
        check("reached addr4", OutAddr, 3'd4);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("midreset busy", Busy, 1'b0);
        check("midreset done", Done, 1'b0);
        check("midreset valid", OutValid, 1'b0);
        check("midreset addr", OutAddr, 3'd0);
        check("midreset data", OutData, 8'd0);
        check("midreset raddrA", RaddrA, 3'd0);
        check("midreset raddrB", RaddrB, 3'd1);
        step();
        check("midreset no done", Done, 1'b0);
        check("midreset stays idle", Busy, 1'b0);
        exp_data = regs;
        do_dump(0);

        Reset = 1'b1;
        Start = 1'b1;
        step();
        Reset = 1'b0;
        Start = 1'b0;
        check("rst+start busy", Busy, 1'b0);
        step();
        check("rst+start idle", Busy, 1'b0);
        do_dump(0);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
            exp_data = regs;
            do_dump(4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
